// File: rtl/cpu_wb_bridge_p.sv
// CPU memory port to Wishbone classic master bridge, one outstanding transfer.
// Adds byte enables, a busy/done/error handshake, err_i support and an optional bus timeout.
module cpu_wb_bridge_p #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [ADDR_W-1:0]   memAdr,
    input  logic [DATA_W-1:0]   memwrData,
    input  logic [DATA_W/8-1:0] memBe,
    input  logic                memWe,
    input  logic                memRd,
    output logic [DATA_W-1:0]   memrdData,
    output logic                memBusy,
    output logic                memDone,
    output logic                memErr,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    output logic                we_o,
    output logic                stb_o,
    output logic [DATA_W/8-1:0] sel_o,
    output logic                cyc_o,
    input  logic                ack_i,
    input  logic                err_i
);

    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            memrdData <= '0;
            memBusy   <= 1'b0;
            memDone   <= 1'b0;
            memErr    <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            we_o      <= 1'b0;
            stb_o     <= 1'b0;
            sel_o     <= {SEL_W{1'b0}};
            cyc_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (memWe && memRd) begin
                        // Conflicting request: report an error without touching the bus
                        memBusy <= 1'b1;
                        memDone <= 1'b1;
                        memErr  <= 1'b1;
                        state   <= RESP;
                    end else if (memWe || memRd) begin
                        wb_adr_o <= memAdr;
                        wb_dat_o <= memwrData;
                        sel_o    <= memBe;
                        we_o     <= memWe;
                        cyc_o    <= 1'b1;
                        stb_o    <= 1'b1;
                        memBusy  <= 1'b1;
                        cnt      <= '0;
                        state    <= BUS;
                    end
                end
                BUS: begin
                    // err_i wins over ack_i, and ack_i wins over a timeout on the same edge
                    if (err_i) begin
                        cyc_o   <= 1'b0;
                        stb_o   <= 1'b0;
                        memDone <= 1'b1;
                        memErr  <= 1'b1;
                        state   <= RESP;
                    end else if (ack_i) begin
                        cyc_o   <= 1'b0;
                        stb_o   <= 1'b0;
                        memDone <= 1'b1;
                        memErr  <= 1'b0;
                        if (!we_o) begin
                            memrdData <= wb_dat_i;
                        end
                        state   <= RESP;
                    end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                        cyc_o   <= 1'b0;
                        stb_o   <= 1'b0;
                        memDone <= 1'b1;
                        memErr  <= 1'b1;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    memDone <= 1'b0;
                    memErr  <= 1'b0;
                    memBusy <= 1'b0;
                    cnt     <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_wb_bridge_p.sv
// Self-checking bench for cpu_wb_bridge_p: directed scenarios plus randomized transfers
// checked against a transaction-level outcome model.
module tb_cpu_wb_bridge_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int passCnt  = 0;
    int totalCnt = 0;

    // Main instance: 32-bit, TIMEOUT=16
    logic        rstn;
    logic [31:0] memAdr, memwrData, memrdData, wbAdr, wbDatO, wbDatI;
    logic [3:0]  memBe, selO;
    logic        memWe, memRd, memBusy, memDone, memErr, weO, stbO, cycO, ackI, errI;

    cpu_wb_bridge_p #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .resetn(rstn), .memAdr(memAdr), .memwrData(memwrData), .memBe(memBe),
        .memWe(memWe), .memRd(memRd), .memrdData(memrdData), .memBusy(memBusy),
        .memDone(memDone), .memErr(memErr), .wb_adr_o(wbAdr), .wb_dat_o(wbDatO),
        .wb_dat_i(wbDatI), .we_o(weO), .stb_o(stbO), .sel_o(selO), .cyc_o(cycO),
        .ack_i(ackI), .err_i(errI));

    // Timeout-disabled instance
    logic        zRstn;
    logic [31:0] zAdr, zWdat, zRdat, zWbAdr, zWbDatO, zWbDatI;
    logic [3:0]  zBe, zSel;
    logic        zWe, zRd, zBusy, zDone, zErr, zWeO, zStb, zCyc, zAck, zErrI;

    cpu_wb_bridge_p #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut0 (
        .clk(clk), .resetn(zRstn), .memAdr(zAdr), .memwrData(zWdat), .memBe(zBe),
        .memWe(zWe), .memRd(zRd), .memrdData(zRdat), .memBusy(zBusy),
        .memDone(zDone), .memErr(zErr), .wb_adr_o(zWbAdr), .wb_dat_o(zWbDatO),
        .wb_dat_i(zWbDatI), .we_o(zWeO), .stb_o(zStb), .sel_o(zSel), .cyc_o(zCyc),
        .ack_i(zAck), .err_i(zErrI));

    // 64-bit data instance
    logic        wRstn;
    logic [31:0] wAdr, wWbAdr;
    logic [63:0] wWdat, wRdat, wWbDatO, wWbDatI;
    logic [7:0]  wBe, wSel;
    logic        wWe, wRd, wBusy, wDone, wErr, wWeO, wStb, wCyc, wAck, wErrI;

    cpu_wb_bridge_p #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(16)) dut64 (
        .clk(clk), .resetn(wRstn), .memAdr(wAdr), .memwrData(wWdat), .memBe(wBe),
        .memWe(wWe), .memRd(wRd), .memrdData(wRdat), .memBusy(wBusy),
        .memDone(wDone), .memErr(wErr), .wb_adr_o(wWbAdr), .wb_dat_o(wWbDatO),
        .wb_dat_i(wWbDatI), .we_o(wWeO), .stb_o(wStb), .sel_o(wSel), .cyc_o(wCyc),
        .ack_i(wAck), .err_i(wErrI));

    // Reference model state: last successfully read word
    logic [31:0] expRd;

    // Observations of one transfer on the main instance
    int          obsCyc, obsLat;
    bit          obsDone, obsStable;
    logic        obsErr, obsWe;
    logic [31:0] obsAdr, obsDat;
    logic [3:0]  obsSel;

    // Transaction outcome from the rules: who answers first, or whether the timeout fires
    function automatic void predict(input logic we, input logic rd, input int waitCyc,
                                    input logic giveAck, input logic giveErr, input int tmo,
                                    output int eCyc, output int eLat, output logic eErr,
                                    output logic eUpd);
        if (we && rd) begin
            eCyc = 0; eLat = 1; eErr = 1'b1; eUpd = 1'b0;
        end else if ((giveAck || giveErr) && (tmo == 0 || waitCyc < tmo)) begin
            eCyc = waitCyc + 1; eLat = waitCyc + 2; eErr = giveErr; eUpd = rd && !giveErr;
        end else begin
            eCyc = tmo; eLat = tmo + 1; eErr = 1'b1; eUpd = 1'b0;
        end
    endfunction

    // Issue one request; the slave answers after waitCyc cycles with cyc_o high
    task automatic run_txn(input logic we, input logic rd, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] be, input int waitCyc,
                           input logic giveAck, input logic giveErr, input logic [31:0] rdat,
                           input bit holdReq);
        bit seen;
        @(negedge clk);
        memWe = we; memRd = rd; memAdr = adr; memwrData = dat; memBe = be;
        obsCyc = 0; obsLat = -1; obsDone = 0; obsErr = 1'b0; obsStable = 1; seen = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (holdReq) begin
                memAdr = 32'h0000_0BAD; memwrData = ~dat; memBe = ~be;
            end else begin
                memWe = 1'b0; memRd = 1'b0;
            end
            ackI = 1'b0; errI = 1'b0; wbDatI = $urandom;
            if (cycO) begin
                obsCyc++;
                if (!seen) begin
                    obsAdr = wbAdr; obsDat = wbDatO; obsSel = selO; obsWe = weO; seen = 1;
                end else if (wbAdr !== obsAdr || wbDatO !== obsDat || selO !== obsSel || weO !== obsWe) begin
                    obsStable = 0;
                end
                if (stbO !== 1'b1 || memBusy !== 1'b1) obsStable = 0;
                if (obsCyc - 1 == waitCyc) begin
                    ackI = giveAck; errI = giveErr; wbDatI = rdat;
                end
            end
            if (memDone) begin
                obsDone = 1; obsErr = memErr; obsLat = k;
                break;
            end
        end
        memWe = 1'b0; memRd = 1'b0; ackI = 1'b0; errI = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; zRstn = 1'b0; wRstn = 1'b0;
        repeat (3) @(negedge clk);
        totalCnt++;
        if ({cycO, stbO, weO, memBusy, memDone, memErr, selO, wbAdr, wbDatO, memrdData} !== '0)
            $display("[TB] FAIL reset_main: outputs %h required all zero",
                     {cycO, stbO, weO, memBusy, memDone, memErr, selO, wbAdr, wbDatO, memrdData});
        else passCnt++;
        totalCnt++;
        if ({zCyc, zStb, zWeO, zBusy, zDone, zErr, zSel, zWbAdr, zWbDatO, zRdat} !== '0)
            $display("[TB] FAIL reset_nto: outputs nonzero, required all zero");
        else passCnt++;
        totalCnt++;
        if ({wCyc, wStb, wWeO, wBusy, wDone, wErr, wSel, wWbAdr, wWbDatO, wRdat} !== '0)
            $display("[TB] FAIL reset_w64: outputs nonzero, required all zero");
        else passCnt++;
        rstn = 1'b1; zRstn = 1'b1; wRstn = 1'b1;
        expRd = '0;
        @(negedge clk);
    endtask

    task automatic test_write();
        run_txn(1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 4'hF, 2, 1'b1, 1'b0, 32'h5555_5555, 0);
        totalCnt++;
        if (obsCyc !== 3) $display("[TB] FAIL write_cyc_len: got %0d required 3", obsCyc);
        else passCnt++;
        totalCnt++;
        if ({obsAdr, obsDat, obsSel, obsWe} !== {32'h100, 32'hDEAD_BEEF, 4'hF, 1'b1})
            $display("[TB] FAIL write_bus_fields: got adr=%h dat=%h sel=%h we=%b required 100/deadbeef/f/1",
                     obsAdr, obsDat, obsSel, obsWe);
        else passCnt++;
        totalCnt++;
        if (!obsStable) $display("[TB] FAIL write_stable: got unstable required stable");
        else passCnt++;
        totalCnt++;
        if ({obsDone, obsErr} !== 2'b10) $display("[TB] FAIL write_done: got done=%b err=%b required 1/0", obsDone, obsErr);
        else passCnt++;
        totalCnt++;
        if (memrdData !== expRd) $display("[TB] FAIL write_rddata: got %h required %h", memrdData, expRd);
        else passCnt++;
        @(negedge clk);
        totalCnt++;
        if ({memDone, memErr, memBusy} !== 3'b000)
            $display("[TB] FAIL write_after_resp: got done/err/busy=%b required 000", {memDone, memErr, memBusy});
        else passCnt++;
    endtask

    task automatic test_read();
        run_txn(1'b0, 1'b1, 32'h204, $urandom, 4'h3, 0, 1'b1, 1'b0, 32'h1234_5678, 0);
        expRd = 32'h1234_5678;
        totalCnt++;
        if (obsLat !== 2) $display("[TB] FAIL read_latency: got %0d required 2", obsLat);
        else passCnt++;
        totalCnt++;
        if (memrdData !== expRd) $display("[TB] FAIL read_data: got %h required %h", memrdData, expRd);
        else passCnt++;
        totalCnt++;
        if ({obsWe, obsSel, obsErr} !== {1'b0, 4'h3, 1'b0})
            $display("[TB] FAIL read_fields: got we=%b sel=%h err=%b required 0/3/0", obsWe, obsSel, obsErr);
        else passCnt++;
    endtask

    task automatic test_error();
        run_txn(1'b0, 1'b1, 32'h208, 32'h0, 4'hF, 1, 1'b1, 1'b1, 32'hCAFE_BABE, 0);
        totalCnt++;
        if ({obsDone, obsErr} !== 2'b11) $display("[TB] FAIL error_flags: got done=%b err=%b required 1/1", obsDone, obsErr);
        else passCnt++;
        totalCnt++;
        if (memrdData !== expRd) $display("[TB] FAIL error_rddata: got %h required %h", memrdData, expRd);
        else passCnt++;
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 1'b1, 32'h300, 32'h0, 4'hF, 0, 1'b0, 1'b0, 32'h0, 0);
        totalCnt++;
        if (obsCyc !== 16) $display("[TB] FAIL timeout_cyc_len: got %0d required 16", obsCyc);
        else passCnt++;
        totalCnt++;
        if ({obsDone, obsErr} !== 2'b11 || obsLat !== 17)
            $display("[TB] FAIL timeout_flags: got done=%b err=%b lat=%0d required 1/1/17", obsDone, obsErr, obsLat);
        else passCnt++;
        totalCnt++;
        if (memrdData !== expRd) $display("[TB] FAIL timeout_rddata: got %h required %h", memrdData, expRd);
        else passCnt++;
        // Ack on the very edge the timeout would fire
        run_txn(1'b0, 1'b1, 32'h304, 32'h0, 4'hF, 15, 1'b1, 1'b0, 32'hA5A5_5A5A, 0);
        expRd = 32'hA5A5_5A5A;
        totalCnt++;
        if (obsCyc !== 16 || obsErr !== 1'b0 || memrdData !== expRd)
            $display("[TB] FAIL timeout_ack_wins: got cyc=%0d err=%b data=%h required 16/0/%h",
                     obsCyc, obsErr, memrdData, expRd);
        else passCnt++;
    endtask

    task automatic test_timeout_disabled();
        int hi;
        bit doneSeen;
        hi = 0; doneSeen = 0;
        @(negedge clk);
        zRd = 1'b1; zAdr = 32'h40;
        @(negedge clk);
        zRd = 1'b0;
        for (int k = 0; k < 120; k++) begin
            if (zCyc) hi++;
            if (zDone) doneSeen = 1;
            @(negedge clk);
        end
        totalCnt++;
        if (hi !== 120 || doneSeen) $display("[TB] FAIL no_timeout: got cyc_high=%0d done=%b required 120/0", hi, doneSeen);
        else passCnt++;
        zRstn = 1'b0;
        @(negedge clk);
        zRstn = 1'b1;
    endtask

    task automatic test_illegal();
        run_txn(1'b1, 1'b1, 32'h500, 32'h1, 4'hF, 0, 1'b1, 1'b0, 32'h0, 0);
        totalCnt++;
        if (obsCyc !== 0 || {obsDone, obsErr} !== 2'b11 || obsLat !== 1)
            $display("[TB] FAIL illegal_req: got cyc=%0d done=%b err=%b lat=%0d required 0/1/1/1",
                     obsCyc, obsDone, obsErr, obsLat);
        else passCnt++;
    endtask

    task automatic test_busy();
        int extra;
        extra = 0;
        run_txn(1'b0, 1'b1, 32'h400, 32'h0, 4'h5, 3, 1'b1, 1'b0, 32'h0BAD_F00D, 1);
        expRd = 32'h0BAD_F00D;
        totalCnt++;
        if (obsCyc !== 4 || obsAdr !== 32'h400 || obsSel !== 4'h5 || !obsStable)
            $display("[TB] FAIL busy_ignore: got cyc=%0d adr=%h sel=%h stable=%b required 4/400/5/1",
                     obsCyc, obsAdr, obsSel, obsStable);
        else passCnt++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (cycO) extra++;
        end
        totalCnt++;
        if (extra !== 0 || memrdData !== expRd)
            $display("[TB] FAIL busy_single_txn: got extra_cyc=%0d data=%h required 0/%h", extra, memrdData, expRd);
        else passCnt++;
    endtask

    task automatic test_reset_mid();
        bit doneSeen;
        doneSeen = 0;
        @(negedge clk);
        memWe = 1'b1; memAdr = 32'h600; memwrData = 32'h77; memBe = 4'hC;
        @(negedge clk);
        memWe = 1'b0;
        @(negedge clk);
        totalCnt++;
        if (cycO !== 1'b1) $display("[TB] FAIL midreset_pre: got cyc=%b required 1", cycO);
        else passCnt++;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        totalCnt++;
        if ({cycO, stbO, weO, memBusy, memDone, memErr, selO, wbAdr, wbDatO, memrdData} !== '0)
            $display("[TB] FAIL midreset_outputs: got cyc=%b stb=%b busy=%b adr=%h required all zero",
                     cycO, stbO, memBusy, wbAdr);
        else passCnt++;
        expRd = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (memDone || cycO) doneSeen = 1;
        end
        totalCnt++;
        if (doneSeen) $display("[TB] FAIL midreset_no_done: got activity=1 required 0");
        else passCnt++;
    endtask

    task automatic test_write64();
        int hi;
        bit doneSeen;
        logic capOk;
        hi = 0; doneSeen = 0; capOk = 1'b0;
        @(negedge clk);
        wWe = 1'b1; wAdr = 32'h100; wWdat = 64'hDEAD_BEEF_CAFE_F00D; wBe = 8'hF0;
        for (int k = 0; k < 40 && !doneSeen; k++) begin
            @(negedge clk);
            wWe = 1'b0; wAck = 1'b0;
            if (wCyc) begin
                hi++;
                if (hi == 1) capOk = (wSel === 8'hF0 && wWbDatO === 64'hDEAD_BEEF_CAFE_F00D &&
                                      wWbAdr === 32'h100 && wWeO === 1'b1);
                if (hi == 3) wAck = 1'b1;
            end
            if (wDone) begin
                doneSeen = 1;
                totalCnt++;
                if (wErr !== 1'b0) $display("[TB] FAIL w64_err: got %b required 0", wErr);
                else passCnt++;
            end
        end
        wAck = 1'b0;
        totalCnt++;
        if (!doneSeen || hi !== 3) $display("[TB] FAIL w64_done: got done=%b cyc=%0d required 1/3", doneSeen, hi);
        else passCnt++;
        totalCnt++;
        if (capOk !== 1'b1 || wRdat !== 64'h0)
            $display("[TB] FAIL w64_fields: got fields_ok=%b rddata=%h required 1/0", capOk, wRdat);
        else passCnt++;
    endtask

    task automatic test_random();
        int kind, waitCyc, resp, eCyc, eLat;
        logic we, rd, eErr, eUpd, gA, gE;
        logic [31:0] adr, dat, rdat;
        logic [3:0] be;
        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 2);
            we = (kind != 1); rd = (kind != 0);
            waitCyc = $urandom_range(0, 20);
            resp = $urandom_range(0, 3);
            gA = resp[0]; gE = resp[1];
            adr = $urandom; dat = $urandom; rdat = $urandom; be = 4'($urandom);
            predict(we, rd, waitCyc, gA, gE, 16, eCyc, eLat, eErr, eUpd);
            run_txn(we, rd, adr, dat, be, waitCyc, gA, gE, rdat, 0);
            if (eUpd) expRd = rdat;
            totalCnt++;
            if (obsCyc !== eCyc || obsLat !== eLat || obsErr !== eErr || !obsDone)
                $display("[TB] FAIL rand_outcome[%0d]: got cyc=%0d lat=%0d err=%b required %0d/%0d/%b",
                         n, obsCyc, obsLat, obsErr, eCyc, eLat, eErr);
            else passCnt++;
            totalCnt++;
            if (memrdData !== expRd) $display("[TB] FAIL rand_rddata[%0d]: got %h required %h", n, memrdData, expRd);
            else passCnt++;
            if (eCyc > 0) begin
                totalCnt++;
                if ({obsAdr, obsDat, obsSel, obsWe} !== {adr, dat, be, we} || !obsStable)
                    $display("[TB] FAIL rand_bus[%0d]: got adr=%h dat=%h sel=%h we=%b required %h/%h/%h/%b",
                             n, obsAdr, obsDat, obsSel, obsWe, adr, dat, be, we);
                else passCnt++;
            end
        end
    endtask

    initial begin
        memWe = 0; memRd = 0; memAdr = 0; memwrData = 0; memBe = 0; wbDatI = 0; ackI = 0; errI = 0;
        zWe = 0; zRd = 0; zAdr = 0; zWdat = 0; zBe = 0; zWbDatI = 0; zAck = 0; zErrI = 0;
        wWe = 0; wRd = 0; wAdr = 0; wWdat = 0; wBe = 0; wWbDatI = 0; wAck = 0; wErrI = 0;
        test_reset();
        test_write();
        test_read();
        test_error();
        test_timeout();
        test_timeout_disabled();
        test_illegal();
        test_busy();
        test_reset_mid();
        test_write64();
        test_random();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
